// File: rtl/keypad_code_entry.sv
// Keypad code-entry controller: decodes one-hot key presses, buffers BCD digits,
// checks the entry against a reference code and enforces a timed lockout.
module keypad_code_entry #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned MAX_TRIES   = 5,
   parameter int unsigned LOCK_CYCLES = 100000000,
   parameter int unsigned CW          = $clog2(DIGITS + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [15:0]           onehot,
   input  logic [4*DIGITS-1:0]   code_ref,
   output logic [3:0]            digit,
   output logic                  digit_valid,
   output logic [4*DIGITS-1:0]   entry,
   output logic [CW-1:0]         count,
   output logic [7:0]            tries,
   output logic                  pass,
   output logic                  fail,
   output logic                  locked
);

   localparam int unsigned EW = 4 * DIGITS;
   localparam int unsigned TW = 32;

   typedef enum logic [1:0] {S_ENTRY, S_CHECK, S_LOCK} state_t;

   state_t          state;
   logic [15:0]     prev;
   logic [TW-1:0]   timer;
   logic            key_digit;
   logic            key_enter;
   logic            key_clear;
   logic [3:0]      key_val;
   logic            press;
   logic            lock_done;
   logic [7:0]      tries_inc;

   // Key map decode; ignored keys and multi-bit values fall through to no key
   always_comb begin
      key_digit = 1'b0;
      key_enter = 1'b0;
      key_clear = 1'b0;
      key_val   = 4'd0;
      case (onehot)
         16'h0008: begin key_digit = 1'b1; key_val = 4'd0; end
         16'h0080: begin key_digit = 1'b1; key_val = 4'd1; end
         16'h0040: begin key_digit = 1'b1; key_val = 4'd2; end
         16'h0020: begin key_digit = 1'b1; key_val = 4'd3; end
         16'h0800: begin key_digit = 1'b1; key_val = 4'd4; end
         16'h0400: begin key_digit = 1'b1; key_val = 4'd5; end
         16'h0200: begin key_digit = 1'b1; key_val = 4'd6; end
         16'h8000: begin key_digit = 1'b1; key_val = 4'd7; end
         16'h4000: begin key_digit = 1'b1; key_val = 4'd8; end
         16'h2000: begin key_digit = 1'b1; key_val = 4'd9; end
         16'h0001: key_enter = 1'b1;
         16'h0010: key_clear = 1'b1;
         default: ;
      endcase
   end

   // A press only counts when the previous sample was fully released
   assign press     = (prev == 16'h0000) && (key_digit || key_enter || key_clear);
   assign lock_done = (LOCK_CYCLES != 0) && (timer == TW'(LOCK_CYCLES - 1));
   assign tries_inc = tries + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_ENTRY;
         prev        <= 16'h0000;
         timer       <= '0;
         digit       <= 4'd0;
         digit_valid <= 1'b0;
         entry       <= '0;
         count       <= '0;
         tries       <= 8'd0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         locked      <= 1'b0;
      end else begin
         prev        <= onehot;
         digit_valid <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         case (state)
            S_ENTRY: begin
               if (press) begin
                  if (key_digit) begin
                     digit       <= key_val;
                     digit_valid <= 1'b1;
                     if (count != CW'(DIGITS)) begin
                        entry <= EW'({entry, key_val});
                        count <= count + CW'(1);
                     end
                  end else if (key_clear) begin
                     entry <= '0;
                     count <= '0;
                  end else if (count == CW'(DIGITS)) begin
                     state <= S_CHECK;
                  end
               end
            end
            S_CHECK: begin
               entry <= '0;
               count <= '0;
               if (entry == code_ref) begin
                  pass  <= 1'b1;
                  tries <= 8'd0;
                  state <= S_ENTRY;
               end else begin
                  fail  <= 1'b1;
                  tries <= tries_inc;
                  if (tries_inc == 8'(MAX_TRIES)) begin
                     state  <= S_LOCK;
                     locked <= 1'b1;
                     timer  <= '0;
                  end else begin
                     state <= S_ENTRY;
                  end
               end
            end
            S_LOCK: begin
               if (lock_done) begin
                  locked <= 1'b0;
                  tries  <= 8'd0;
                  state  <= S_ENTRY;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: state <= S_ENTRY;
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Scoreboard bench for keypad_code_entry: a queue-based reference model predicts
// every pulse and the visible buffer/try/lock state each cycle.
module tb_keypad_code_entry;

   localparam int unsigned DIGITS      = 4;
   localparam int unsigned MAX_TRIES   = 5;
   localparam int unsigned LOCK_CYCLES = 20;
   localparam int unsigned CW          = $clog2(DIGITS + 1);
   localparam int unsigned EW          = 4 * DIGITS;

   logic           clk;
   logic           rst_n;
   logic [15:0]    onehot;
   logic [EW-1:0]  code_ref;
   logic [3:0]     digit;
   logic           digit_valid;
   logic [EW-1:0]  entry;
   logic [CW-1:0]  count;
   logic [7:0]     tries;
   logic           pass;
   logic           fail;
   logic           locked;

   keypad_code_entry #(
      .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .onehot(onehot), .code_ref(code_ref),
      .digit(digit), .digit_valid(digit_valid), .entry(entry), .count(count),
      .tries(tries), .pass(pass), .fail(fail), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         kind;   // 0 digit, 1 pass, 2 fail
      int         cyc;
      logic [3:0] dg;
   } exp_t;

   logic [15:0] keymap [12] = '{16'h0008, 16'h0080, 16'h0040, 16'h0020, 16'h0800, 16'h0400,
                                16'h0200, 16'h8000, 16'h4000, 16'h2000, 16'h0001, 16'h0010};
   logic [15:0] unmapped [4] = '{16'h0002, 16'h0004, 16'h0100, 16'h1000};

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          dv_cnt = 0;
   int          pass_cnt = 0;
   int          fail_cnt = 0;

   // Reference model state: digit queue (oldest first), mode, tries, lock countdown
   int          m_q[$];
   int          m_mode;
   int          m_tries;
   int          m_lock_left;
   bit          m_locked;
   logic [15:0] m_prev;

   function automatic int key_to_sym(input logic [15:0] k);
      for (int i = 0; i < 12; i++) if (k == keymap[i]) return i;
      return -1;
   endfunction

   function automatic logic [EW-1:0] q_entry();
      logic [EW-1:0] v = '0;
      foreach (m_q[i]) v = EW'({v, 4'(m_q[i])});
      return v;
   endfunction

   function automatic logic [EW-1:0] rand_code();
      logic [EW-1:0] c;
      for (int i = 0; i < int'(DIGITS); i++) c[4*i +: 4] = 4'($urandom_range(0, 9));
      return c;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      exp_t e;
      int   sym;
      if (!rst_n) begin
         m_q.delete();
         m_mode = 0; m_tries = 0; m_lock_left = 0; m_locked = 0; m_prev = 16'h0;
         sb.delete();
      end else begin
         cyc++;
         sym = (m_prev == 16'h0) ? key_to_sym(onehot) : -1;
         m_prev = onehot;
         e.cyc = cyc; e.dg = 4'd0; e.kind = 0;
         if (m_mode == 1) begin
            if (q_entry() == code_ref) begin
               e.kind = 1; m_tries = 0; m_mode = 0;
            end else begin
               e.kind = 2; m_tries++;
               if (m_tries == int'(MAX_TRIES)) begin
                  m_mode = 2; m_locked = 1; m_lock_left = int'(LOCK_CYCLES);
               end else m_mode = 0;
            end
            m_q.delete();
            sb.push_back(e);
         end else if (m_mode == 2) begin
            m_lock_left--;
            if (m_lock_left == 0) begin m_mode = 0; m_locked = 0; m_tries = 0; end
         end else if (sym >= 0 && sym <= 9) begin
            if (m_q.size() < int'(DIGITS)) m_q.push_back(sym);
            e.dg = 4'(sym);
            sb.push_back(e);
         end else if (sym == 11) begin
            m_q.delete();
         end else if (sym == 10 && m_q.size() == int'(DIGITS)) begin
            m_mode = 1;
         end
      end
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      int   ak;
      if (rst_n) begin
         if (digit_valid || pass || fail) begin
            vectors++;
            ak = digit_valid ? 0 : (pass ? 1 : 2);
            if (digit_valid) dv_cnt++;
            if (pass) pass_cnt++;
            if (fail) fail_cnt++;
            if ($countones({digit_valid, pass, fail}) != 1) begin
               miscompares++;
               $display("FAIL pulse_overlap cyc=%0d: dv=%b pass=%b fail=%b, required at most one",
                        cyc, digit_valid, pass, fail);
            end else if (sb.size() == 0 || sb[0].cyc != cyc) begin
               miscompares++;
               $display("FAIL spurious_pulse cyc=%0d: kind=%0d seen, none expected", cyc, ak);
            end else begin
               e = sb.pop_front();
               if (e.kind != ak || (ak == 0 && digit !== e.dg)) begin
                  miscompares++;
                  $display("FAIL pulse cyc=%0d: kind=%0d digit=%0d, expected kind=%0d digit=%0d",
                           cyc, ak, digit, e.kind, e.dg);
               end
            end
         end
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++; miscompares++;
            $display("FAIL missed_pulse cyc=%0d: nothing seen, expected kind=%0d", e.cyc, e.kind);
         end
         vectors++;
         if (entry !== q_entry() || int'(count) != m_q.size() || int'(tries) != m_tries ||
             locked !== m_locked) begin
            miscompares++;
            $display("FAIL state cyc=%0d: entry=%h count=%0d tries=%0d locked=%b, expected %h %0d %0d %b",
                     cyc, entry, count, tries, locked, q_entry(), m_q.size(), m_tries, m_locked);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic hold(input logic [15:0] k, input int n);
      onehot = k;
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic tap(input logic [15:0] k);
      hold(k, int'($urandom_range(1, 3)));
      hold(16'h0, int'($urandom_range(1, 2)));
   endtask

   task automatic type_code(input logic [EW-1:0] c);
      for (int i = int'(DIGITS) - 1; i >= 0; i--) tap(keymap[int'(c[4*i +: 4])]);
   endtask

   task automatic wait_unlock();
      int n = 0;
      while (locked && n < 60) begin @(posedge clk); #2; n++; end
      chk("lock_exit_timeout", 32'(locked), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_outs"}, {digit, 3'b0, digit_valid, 8'(count), tries, 3'b0, pass, fail, locked},
          32'd0);
      chk({tag, "_entry"}, 32'(entry), 32'd0);
   endtask

   initial begin
      int p0, d0, f0, r;
      logic [15:0] k;
      onehot = 16'h0; code_ref = 16'h1234; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #2;

      tap(16'h0080); tap(16'h0040); tap(16'h0020); tap(16'h0800);
      chk("entry_1234", 32'(entry), 32'h1234);
      chk("count_4", 32'(count), 32'd4);
      chk("dv_four", 32'(dv_cnt), 32'd4);

      tap(keymap[10]);
      hold(16'h0, 3);
      chk("pass_once", 32'(pass_cnt), 32'd1);
      chk("no_fail", 32'(fail_cnt), 32'd0);
      chk("entry_cleared", 32'(entry), 32'd0);

      d0 = dv_cnt;
      hold(16'h0008, 50); hold(16'h0, 2);
      chk("held_key_one_event", 32'(dv_cnt - d0), 32'd1);
      chk("held_key_digit0", 32'(digit), 32'd0);
      tap(16'h0088);
      chk("multibit_no_event", 32'(dv_cnt - d0), 32'd1);
      tap(keymap[5]); tap(keymap[6]); tap(keymap[7]);
      d0 = dv_cnt;
      tap(keymap[9]);
      chk("overflow_dv", 32'(dv_cnt - d0), 32'd1);
      chk("overflow_digit", 32'(digit), 32'd9);
      chk("overflow_entry", 32'(entry), 32'h0567);

      tap(keymap[11]);
      tap(keymap[1]); tap(keymap[2]);
      p0 = pass_cnt; f0 = fail_cnt;
      tap(keymap[10]); hold(16'h0, 3);
      chk("short_enter_no_pulse", 32'(pass_cnt + fail_cnt), 32'(p0 + f0));
      chk("short_enter_entry", 32'(entry), 32'h0012);
      tap(keymap[11]);
      chk("clear_count", 32'(count), 32'd0);

      // Five wrong codes lock the pad; keys held across the exit must not fire
      f0 = fail_cnt;
      for (int i = 0; i < int'(MAX_TRIES); i++) begin type_code(16'h5555); tap(keymap[10]); end
      chk("lock_fail_count", 32'(fail_cnt - f0), 32'(MAX_TRIES));
      chk("locked_high", 32'(locked), 32'd1);
      chk("tries_max", 32'(tries), 32'(MAX_TRIES));
      tap(keymap[3]);
      hold(keymap[1], 25);
      hold(16'h0, 2);
      wait_unlock();
      chk("tries_after_lock", 32'(tries), 32'd0);

      for (int i = 0; i < int'(MAX_TRIES); i++) begin type_code(16'h9876); tap(keymap[10]); end
      hold(16'h0, 4);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      p0 = pass_cnt;
      type_code(16'h1234); tap(keymap[10]); hold(16'h0, 3);
      chk("pass_after_reset", 32'(pass_cnt - p0), 32'd1);

      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 19) == 0) code_ref = rand_code();
         if (r < 55)      k = keymap[$urandom_range(0, 9)];
         else if (r < 63) k = keymap[10];
         else if (r < 68) k = keymap[11];
         else if (r < 78) k = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
         else if (r < 86) k = unmapped[$urandom_range(0, 3)];
         else if (r < 93) begin
            hold(keymap[$urandom_range(0, 11)], int'($urandom_range(1, 2)));
            k = keymap[$urandom_range(0, 9)];
         end else begin
            tap(keymap[11]); type_code(code_ref); k = keymap[10];
         end
         tap(k);
      end
      hold(16'h0, 30);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/keypad_code_entry.md
Name: keypad_code_entry

Overview:
Parametrised keypad code-entry controller for the 4x4 matrix keypad path. It takes the registered one-hot key vector and decodes the digit keys 0-9 plus ENTER and CLEAR. It detects discrete key presses, shifts digits into a DIGITS-deep entry buffer and compares the buffer against a reference code on ENTER. It counts failed tries and enforces a timed lockout after MAX_TRIES consecutive failures. It sits between the keypad scanner/debouncer and the 7-segment display/status logic.

Parameters:
DIGITS, 4, number of BCD digits in a code (1..8)
MAX_TRIES, 5, consecutive failures that trigger lockout (1..255)
LOCK_CYCLES, 100000000, lockout duration in clk cycles; 0 = locked until reset
CW, $clog2(DIGITS+1), width of count output (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
onehot  in  16  debounced one-hot key vector, 0 = no key
code_ref  in  4*DIGITS  reference code, digit 0 in bits [3:0]; sampled only in CHECK
digit  out  4  last accepted digit
digit_valid  out  1  one-cycle pulse per accepted digit
entry  out  4*DIGITS  entry buffer, newest digit in [3:0]
count  out  CW  digits currently held (0..DIGITS)
tries  out  8  consecutive failed attempts
pass  out  1  one-cycle pulse, code matched
fail  out  1  one-cycle pulse, code mismatched
locked  out  1  high while in lockout

Behaviour:
- Key map: 0x0008=0, 0x0080=1, 0x0040=2, 0x0020=3, 0x0800=4, 0x0400=5, 0x0200=6, 0x8000=7, 0x4000=8, 0x2000=9, 0x0001=ENTER, 0x0010=CLEAR. Bits 1, 2, 8 and 12 are ignored keys.
- Press event: fires at the edge where onehot is exactly one mapped bit and the previous-cycle sample (prev register) was 0x0000. A held key produces one event. Multi-bit or unmapped values produce no event.
- A multi-bit or unmapped value followed directly by a valid single bit (prev != 0) produces no event.
- Reset values: digit=0, digit_valid=0, entry=0, count=0, tries=0, pass=0, fail=0, locked=0, prev=0, lock timer=0, state=ENTRY.
- States: ENTRY, CHECK, LOCK.
- ENTRY, digit event:
  - digit and digit_valid are registered at the event edge.
  - If count<DIGITS: entry <= {entry[4*DIGITS-5:0], d}; count++.
  - If count==DIGITS: digit and digit_valid still update; entry and count are unchanged (overflow ignored).
- ENTRY, CLEAR event: entry=0, count=0, no digit_valid.
- ENTRY, ENTER event: if count==DIGITS, go to CHECK; otherwise ignored with no pulse.
- CHECK, one cycle:
  - Compare entry with code_ref.
  - Match: pass=1, tries=0, go to ENTRY.
  - Mismatch: fail=1, tries++. If the new tries==MAX_TRIES, go to LOCK, locked=1, timer=0; otherwise go to ENTRY.
  - In both cases entry=0 and count=0 at this edge.
  - Key events during CHECK are ignored.
- Timing: pass/fail are high in the 2nd cycle after the ENTER edge, i.e. registered at the CHECK edge.
- LOCK:
  - All key events are ignored and digit_valid stays 0.
  - The timer increments each cycle.
  - At timer==LOCK_CYCLES-1: locked=0, tries=0, go to ENTRY.
  - LOCK_CYCLES=0: never exits without reset.
  - prev keeps tracking onehot, so a key held across the lockout exit does not fire.
- tries never exceeds MAX_TRIES; 8-bit width, no wrap.
- Reset asserted in any state (mid-lockout, mid-entry) immediately forces all reset values.
- Pulses never overlap: at most one of digit_valid, pass, fail per cycle.

Test Plan:
- Reset, then press 0x0080, release, 0x0040, release, 0x0020, release, 0x0800, release -> four digit_valid pulses; entry=0x1234, count=4.
- code_ref=0x1234, enter 1,2,3,4 then ENTER -> pass pulse 2 cycles after ENTER edge; entry=0, count=0, tries=0, fail never high.
- Hold 0x0008 for 50 cycles -> exactly one digit_valid, digit=0. Press 0x0088 -> no event. Press a fifth digit when count=4 -> digit_valid pulses, entry unchanged.
- MAX_TRIES=5, LOCK_CYCLES=20, five wrong codes -> fail pulses with tries 1..5; locked=1 after the 5th; keys ignored for 20 cycles; then locked=0, tries=0.
- ENTER with count=2 -> no pass/fail, entry retained. CLEAR -> entry=0, count=0.
- Assert rst_n=0 mid-lockout (tries=5, locked=1) -> all outputs at reset values immediately; after release, a correct code gives a pass pulse.
